aqp_dpram_clr: RTL and testbench
================================

// Module: aqp_dpram_clr
// PURPOSE
//   Parametrised simple-dual-port RAM with a built-in clear engine, write-first
//   read/write collision forwarding and a read-valid strobe. It is the generic
//   successor of the fixed 2Kx8 overlay font RAM. It backs overlay font, text
//   and palette memories that must start from a known state after reset or on
//   request. Single clock domain: the CPU-side writer and the video-side reader
//   share clk.
// PARAMETERS
//   AW       11     address width; depth = 2**AW words
//   DW       8      data width in bits
//   CLR_VAL  0      DW-bit value written to every word by the clear engine
// PORTS
//   clk       in   1    clock; all logic is on the rising edge
//   reset     in   1    synchronous, active-high reset
//   clr_req   in   1    1-cycle pulse: start a full clear (ignored while busy)
//   busy      out  1    clear engine running; external writes are dropped
//   wr_addr   in   AW   write address
//   wr_data   in   DW   write data
//   wr_en     in   1    write strobe
//   rd_addr   in   AW   read address
//   rd_en     in   1    read strobe
//   rd_data   out  DW   read data; holds its value until the next accepted read
//   rd_valid  out  1    1-cycle pulse: rd_data is updated
// BEHAVIOUR
//   Reset values: rd_data=0, rd_valid=0, busy=1, clear address=0, FSM=CLEAR.
//   Memory contents are not reset directly; the clear engine overwrites them.
//   FSM states:
//     CLEAR: each cycle writes CLR_VAL to clr_addr, then clr_addr+1.
//            After writing address 2**AW-1, moves to IDLE. busy=1 in this state.
//     IDLE:  busy=0. clr_req=1 moves to CLEAR with clr_addr=0.
//   Clear timing: after reset deasserts, or after clr_req in IDLE, busy stays
//   high for exactly 2**AW cycles. busy reads 0 on the cycle after the write
//   to the last address.
//   Reset in mid-clear restarts the clear at address 0. No partial state is kept.
//   Writes: when wr_en=1 and busy=0, mem[wr_addr] <= wr_data on that edge.
//   When busy=1, wr_en is ignored and the memory is not modified.
//   Reads: rd_en=1 at edge N gives rd_data and rd_valid=1 after edge N.
//   Latency is 1 cycle. When rd_en=0, rd_valid=0 and rd_data holds.
//   Collision: wr_en and rd_en in the same cycle, same address, busy=0:
//   rd_data = wr_data (write-first). With different addresses, no interaction.
//   Reads while busy=1: rd_valid pulses as normal and rd_data = CLR_VAL,
//   regardless of address or memory contents.
//   clr_req together with wr_en in IDLE: the write is performed, then the clear
//   starts on the next cycle. The clear overwrites the written word.
//   Back-to-back rd_en is allowed every cycle. rd_valid mirrors the delayed
//   rd_en one-for-one.
//   Address arithmetic: clr_addr is AW bits and stops at 2**AW-1; it never
//   wraps while in CLEAR.
// CONFIGURATION
//   AQP_DPRAM_RDREG_EN defined: adds an output register stage for timing.
//     rd_data and rd_valid arrive 2 cycles after rd_en.
//     Collision forwarding and CLR_VAL substitution are decided at the first
//     stage and carried through. Reset clears both stages.
//   Not defined: 1-cycle read latency as described above.
// TESTING
//   1 Reset, AW=4, CLR_VAL=8'hA5 -> busy=1 for 16 cycles after release; then
//     rd_en on addresses 0..15 returns 8'hA5 each, rd_valid=1 one cycle later.
//   2 Write 8'h3C @5, then rd_en @5 -> rd_data=8'h3C, 1 cycle after rd_en
//     (2 cycles with AQP_DPRAM_RDREG_EN).
//   3 Same-cycle wr_en @7 = 8'h11 and rd_en @7 -> rd_data=8'h11; a following
//     read @7 also returns 8'h11.
//   4 In IDLE, pulse clr_req and issue wr_en @3 = 8'hFF while busy ->
//     write dropped; after busy falls, a read @3 returns 8'hA5.
//   5 Assert reset at clear cycle 6 of 16 for 1 cycle -> busy stays 1 for 16
//     more cycles; all 16 words read back 8'hA5.
//   6 Random reads and writes with idle gaps (busy=0) checked against a
//     reference model -> rd_valid count equals rd_en count and no mismatch.

Source files
------------

// File: rtl/aqp_dpram_clr_if.sv
// aqp_dpram_clr_if: write/read/clear bus for the clearable simple-dual-port RAM.
//   master : drives clr_req, wr_addr/wr_data/wr_en, rd_addr/rd_en;
//            samples busy, rd_data, rd_valid
//   slave  : the RAM side of the same signals
interface aqp_dpram_clr_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          clr_req;
  logic          busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  modport master (
    output clr_req, wr_addr, wr_data, wr_en, rd_addr, rd_en,
    input  busy, rd_data, rd_valid
  );

  modport slave (
    input  clr_req, wr_addr, wr_data, wr_en, rd_addr, rd_en,
    output busy, rd_data, rd_valid
  );
endinterface

// File: rtl/aqp_dpram_clr.sv
// aqp_dpram_clr: parametrised simple-dual-port RAM with a clear engine,
// write-first collision forwarding and a read-valid strobe. One clock domain.
//   clk     : clock, rising edge
//   reset   : synchronous, active-high; restarts the clear from address 0
//   bus     : aqp_dpram_clr_if.slave
//             clr_req  start a full clear (ignored while busy)
//             busy     clear engine running, external writes dropped
//             wr_*     write port, rd_* read port
//             rd_data  holds until the next accepted read
//             rd_valid one pulse per accepted read
// Parameters: AW (address width), DW (data width), CLR_VAL (clear pattern).
// Build option: define AQP_DPRAM_RDREG_EN to add an output register stage
// (read latency 2 instead of 1).
module aqp_dpram_clr #(
  parameter int            AW      = 11,
  parameter int            DW      = 8,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  aqp_dpram_clr_if.slave        bus
);

`ifdef AQP_DPRAM_RDREG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif
  localparam int            DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST  = {AW{1'b1}};

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                    state;
  logic [AW-1:0]             clr_addr;
  logic                      busy_q;
  logic [DW-1:0]             mem [DEPTH];
  logic [DW-1:0]             rd_word;
  logic [STAGES:1]           vld_pipe;
  logic [STAGES:1][DW-1:0]   dat_pipe;

  // Clear FSM. busy_q is registered alongside the state so it is a clean flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
      busy_q   <= 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          // Stop at the last word instead of wrapping.
          if (clr_addr == LAST) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        S_IDLE: begin
          if (bus.clr_req) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
            busy_q   <= 1'b1;
          end
        end
        default: begin
          state    <= S_CLEAR;
          clr_addr <= '0;
          busy_q   <= 1'b1;
        end
      endcase
    end
  end

  // Single write port shared by the clear engine and the external writer.
  // Contents are deliberately not reset; the clear engine owns that.
  always_ff @(posedge clk) begin
    if (busy_q)
      mem[clr_addr] <= CLR_VAL;
    else if (bus.wr_en)
      mem[bus.wr_addr] <= bus.wr_data;
  end

  // First-stage read word. While clearing, every address reads the clear
  // pattern (half-cleared memory is never exposed); otherwise a same-address
  // write in this cycle is forwarded.
  always_comb begin
    rd_word = mem[bus.rd_addr];
    if (busy_q)
      rd_word = CLR_VAL;
    else if (bus.wr_en && (bus.wr_addr == bus.rd_addr))
      rd_word = bus.wr_data;
  end

  // Read pipeline: valid shifts every cycle; data only moves with its valid,
  // so the output holds between accepted reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= bus.rd_en;
      if (bus.rd_en)
        dat_pipe[1] <= rd_word;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1])
          dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rd_valid = vld_pipe[STAGES];
  assign bus.rd_data  = dat_pipe[STAGES];

endmodule

// File: tb/tb_aqp_dpram_clr.sv
// Bench for aqp_dpram_clr (AW=4, CLR_VAL=8'hA5): directed vectors with literal
// expectations plus a memory-level reference model checked every cycle.
module tb_aqp_dpram_clr;
  localparam int            AW    = 4;
  localparam int            DW    = 8;
  localparam int            DEPTH = 16;
  localparam logic [7:0]    CV    = 8'hA5;
`ifdef AQP_DPRAM_RDREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  aqp_dpram_clr_if #(.AW(AW), .DW(DW)) bus();

  aqp_dpram_clr #(.AW(AW), .DW(DW), .CLR_VAL(CV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  // Reference model: memory array, remaining clear cycles, and a read FIFO
  // that delays each read result by LAT edges.
  logic [7:0] m_mem [DEPTH];
  int         m_left = 0;
  bit         m_live = 0;
  bit         q_v [$];
  logic [7:0] q_d [$];
  bit         e_valid = 0;
  logic [7:0] e_data  = 8'h00;

  always @(posedge clk) begin
    bit         bz, v, pv;
    logic [7:0] d, pd;
    if (reset) begin
      m_live = 1;
      m_left = DEPTH;
      foreach (m_mem[i]) m_mem[i] = CV;
      q_v.delete();
      q_d.delete();
      for (int i = 0; i < LAT - 1; i++) begin
        q_v.push_back(1'b0);
        q_d.push_back(8'h00);
      end
      e_valid = 0;
      e_data  = 8'h00;
    end else if (m_live) begin
      bz = (m_left > 0);
      v  = bus.rd_en;
      if (bz)
        d = CV;
      else if (bus.wr_en && bus.wr_addr == bus.rd_addr)
        d = bus.wr_data;
      else
        d = m_mem[bus.rd_addr];
      if (!bz && bus.wr_en) m_mem[bus.wr_addr] = bus.wr_data;
      if (bz) m_left--;
      else if (bus.clr_req) begin
        // Net effect of a full clear: every word ends at CV, and reads see
        // CV during the whole clear anyway.
        m_left = DEPTH;
        foreach (m_mem[i]) m_mem[i] = CV;
      end
      q_v.push_back(v);
      q_d.push_back(d);
      pv = q_v.pop_front();
      pd = q_d.pop_front();
      e_valid = pv;
      if (pv) e_data = pd;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_busy",     32'(bus.busy),     32'(m_left > 0));
      chk("model_rd_valid", 32'(bus.rd_valid), 32'(e_valid));
      chk("model_rd_data",  32'(bus.rd_data),  32'(e_data));
    end
  end

  bit cnt_en = 0;
  int n_val  = 0;
  always @(negedge clk) if (cnt_en && bus.rd_valid === 1'b1) n_val++;

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic read_expect(input logic [3:0] a, input logic [7:0] exp, input string nm);
    bus.rd_addr = a;
    bus.rd_en   = 1'b1;
    cyc();
    bus.rd_en   = 1'b0;
    repeat (LAT - 1) cyc();
    chk({nm, "_valid"}, 32'(bus.rd_valid), 32'd1);
    chk(nm, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    cyc();
    bus.wr_en   = 1'b0;
  endtask

  // Counts cycles until busy drops, bounded; an expired bound shows as a bad count.
  task automatic busy_len(input int start, input string nm);
    int n = start;
    while (bus.busy === 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    chk(nm, 32'(n), 32'd16);
  endtask

  initial begin
    int n_rd = 0;
    bus.clr_req = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    reset       = 1'b1;
    cyc();
    cyc();
    chk("reset_busy",     32'(bus.busy),     32'd1);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset_rd_data",  32'(bus.rd_data),  32'h00);

    // 1: initial clear length and contents
    reset = 1'b0;
    busy_len(0, "t1_busy_len");
    for (int a = 0; a < DEPTH; a++) read_expect(4'(a), CV, "t1_read");
    // back-to-back reads, checked by the model
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = 4'(a);
      cyc();
    end
    bus.rd_en = 1'b0;
    repeat (LAT) cyc();

    // 2: plain write then read
    write(4'd5, 8'h3C);
    read_expect(4'd5, 8'h3C, "t2_read5");

    // 3: same-cycle collision forwards write data; different address doesn't
    bus.wr_addr = 4'd7; bus.wr_data = 8'h11; bus.wr_en = 1'b1;
    bus.rd_addr = 4'd7; bus.rd_en   = 1'b1;
    cyc();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    repeat (LAT - 1) cyc();
    chk("t3_collide", 32'(bus.rd_data), 32'h11);
    read_expect(4'd7, 8'h11, "t3_reread7");
    bus.wr_addr = 4'd8; bus.wr_data = 8'h22; bus.wr_en = 1'b1;
    bus.rd_addr = 4'd5; bus.rd_en   = 1'b1;
    cyc();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    repeat (LAT - 1) cyc();
    chk("t3_diffaddr", 32'(bus.rd_data), 32'h3C);
    read_expect(4'd8, 8'h22, "t3_read8");

    // 4: write while busy is dropped; reads while busy return CV
    write(4'd3, 8'h5A);
    bus.clr_req = 1'b1;
    cyc();
    bus.clr_req = 1'b0;
    write(4'd3, 8'hFF);
    read_expect(4'd5, CV, "t4_read_busy");
    busy_len(1 + LAT, "t4_busy_len");
    read_expect(4'd3, CV, "t4_read3");

    // clr_req together with a write: the write lands, then gets cleared
    bus.wr_addr = 4'd9; bus.wr_data = 8'h42; bus.wr_en = 1'b1;
    bus.clr_req = 1'b1;
    cyc();
    bus.wr_en = 1'b0; bus.clr_req = 1'b0;
    busy_len(0, "t4b_busy_len");
    read_expect(4'd9, CV, "t4b_read9");

    // 5: reset in mid-clear restarts the full clear
    write(4'd2, 8'h77);
    bus.clr_req = 1'b1;
    cyc();
    bus.clr_req = 1'b0;
    repeat (5) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t5_rd_data_reset", 32'(bus.rd_data), 32'h00);
    busy_len(0, "t5_busy_len");
    for (int a = 0; a < DEPTH; a++) read_expect(4'(a), CV, "t5_read");

    // 6: random traffic with idle gaps, model-checked
    cyc();
    cnt_en = 1;
    for (int i = 0; i < 300; i++) begin
      bus.wr_en   = ($urandom_range(2) == 0);
      bus.wr_addr = 4'($urandom_range(15));
      bus.wr_data = 8'($urandom_range(255));
      bus.rd_en   = ($urandom_range(2) != 0);
      bus.rd_addr = ($urandom_range(3) == 0) ? bus.wr_addr : 4'($urandom_range(15));
      if (i % 37 > 33) begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
      end
      if (bus.rd_en) n_rd++;
      cyc();
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    repeat (LAT + 1) cyc();
    cnt_en = 0;
    chk("t6_valid_count", 32'(n_val), 32'(n_rd));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
